// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory responder: FSM state encoding,
// address geometry and an alignment check.
package mem_pkg;

  localparam int WORD_BYTES = 4;
  localparam int ADDR_W     = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESP    = 2'd2,
    RELEASE = 2'd3
  } resp_state_t;

  function automatic logic is_aligned(input logic [ADDR_W-1:0] addr);
    return (addr & ADDR_W'(WORD_BYTES - 1)) == '0;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Word-addressed storage with two registered read ports (instruction, data)
// and one synchronous write port. Reads see the pre-write contents on a collision.
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int DATA_W      = 32,
  parameter int IDX         = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_clr,
  output logic [DATA_W-1:0] inst_data,
  input  logic              rd_en,
  input  logic              rd_clr,
  input  logic [IDX-1:0]    rd_idx,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX-1:0]    wr_idx,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];
  logic              inst_in_range;

  // Range check covers the whole byte address, not just the index slice.
  assign inst_in_range = {2'b00, inst_addr[ADDR_W-1:2]} < ADDR_W'(DEPTH_WORDS);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      inst_data <= '0;
      rd_data   <= '0;
    end else begin
      if (inst_clr || !inst_in_range) begin
        inst_data <= '0;
      end else begin
        inst_data <= mem[inst_addr[2 +: IDX]];
      end
      if (rd_clr) begin
        rd_data <= '0;
      end else if (rd_en) begin
        rd_data <= mem[rd_idx];
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: 1-cycle registered instruction fetch plus a
// four-phase handshaked data port with programmable wait states and error reporting.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] address_inst,
  input  logic [ADDR_W-1:0] address_data,
  input  logic [DATA_W-1:0] data_receive,
  input  logic              mem_read,
  input  logic              mem_write,
  output logic [DATA_W-1:0] instruction,
  output logic [DATA_W-1:0] data_send,
  output logic              mem_ready,
  output logic              mem_err,
  output resp_state_t       state
);

  localparam int         IDX       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  resp_state_t       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IDX-1:0]    idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic              write_q, err_q;

  logic              req, in_range, req_illegal, enter_resp;
  logic [IDX-1:0]    idx_cur;
  logic              write_cur, err_cur;
  logic              rd_en, rd_clr, wr_en;

  // Handshake: the core raises mem_read or mem_write and holds it; the responder
  // answers with a single mem_ready pulse (mem_err alongside on rejection), then
  // waits in RELEASE until both requests drop, so one request level is one transaction.
  assign req         = mem_read | mem_write;
  assign in_range    = {2'b00, address_data[ADDR_W-1:2]} < ADDR_W'(DEPTH_WORDS);
  assign req_illegal = (mem_read & mem_write) | !is_aligned(address_data) | !in_range;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (req_illegal || WAIT_CYCLES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d    = RESP;
          enter_resp = 1'b1;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = RELEASE;
      RELEASE: if (!req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Going straight from IDLE to RESP the latched copy is not loaded yet, so use live inputs.
  assign idx_cur   = (state_q == IDLE) ? address_data[2 +: IDX] : idx_q;
  assign write_cur = (state_q == IDLE) ? mem_write : write_q;
  assign err_cur   = (state_q == IDLE) ? req_illegal : err_q;

  assign rd_en  = enter_resp & !write_cur & !err_cur;
  assign rd_clr = enter_resp & err_cur;
  assign wr_en  = rst & (state_q == RESP) & write_q & !err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && req) begin
        idx_q   <= address_data[2 +: IDX];
        wdata_q <= data_receive;
        write_q <= mem_write;
        err_q   <= req_illegal;
      end
    end
  end

  mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .DATA_W     (DATA_W),
    .IDX        (IDX)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .inst_addr(address_inst),
    .inst_clr (start),
    .inst_data(instruction),
    .rd_en    (rd_en),
    .rd_clr   (rd_clr),
    .rd_idx   (idx_cur),
    .rd_data  (data_send),
    .wr_en    (wr_en),
    .wr_idx   (idx_q),
    .wr_data  (wdata_q)
  );

  assign mem_ready = (state_q == RESP);
  assign mem_err   = (state_q == RESP) & err_q;
  assign state     = state_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with DEPTH_WORDS=256, WAIT_CYCLES=2.
module tb_mem_responder;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b1;
  logic [31:0] address_inst = '0;
  logic [31:0] address_data = '0;
  logic [31:0] data_receive = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] instruction, data_send;
  logic        mem_ready, mem_err;
  resp_state_t state;

  int total = 0;
  int bad = 0;

  mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2), .DATA_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .address_inst(address_inst),
    .address_data(address_data),
    .data_receive(data_receive),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .instruction (instruction),
    .data_send   (data_send),
    .mem_ready   (mem_ready),
    .mem_err     (mem_err),
    .state       (state)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Raise a request and wait (bounded) for mem_ready; returns edges counted from the sampling edge.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wd, output int lat, output logic err,
                           output logic [31:0] dout);
    @(negedge clk);
    mem_read = rd; mem_write = wr; address_data = addr; data_receive = wd;
    lat = -1; err = 1'b0; dout = '0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (mem_ready) begin
        lat = k; err = mem_err; dout = data_send;
        break;
      end
    end
  endtask

  task automatic finish_access();
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int lat; logic err; logic [31:0] d;
    repeat (2) @(posedge clk);
    #1;
    total++; if (instruction !== 32'h0) begin bad++; $display("FAIL rst_instruction got=%h exp=0", instruction); end
    total++; if (data_send !== 32'h0) begin bad++; $display("FAIL rst_data_send got=%h exp=0", data_send); end
    total++; if ({mem_ready, mem_err} !== 2'b00) begin bad++; $display("FAIL rst_ready_err got=%b exp=00", {mem_ready, mem_err}); end
    total++; if (state !== IDLE) begin bad++; $display("FAIL rst_state got=%0d exp=0", state); end
    @(negedge clk); rst = 1'b1;
    do_access(1'b0, 1'b1, 32'h4, 32'h11223344, lat, err, d); finish_access();
    do_access(1'b1, 1'b0, 32'h4, 32'h0, lat, err, d); finish_access();
    total++; if (d !== 32'h11223344) begin bad++; $display("FAIL rst_setup_read got=%h exp=11223344", d); end
    @(negedge clk); start = 1'b0; address_inst = 32'h4;
    @(posedge clk); #1;
    total++; if (instruction !== 32'h11223344) begin bad++; $display("FAIL rst_setup_fetch got=%h exp=11223344", instruction); end
    // Reset two cycles in the middle of a read.
    @(negedge clk); mem_read = 1'b1; address_data = 32'h4;
    @(posedge clk);
    @(negedge clk); rst = 1'b0; mem_read = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      total++; if ({instruction, data_send} !== 64'h0) begin bad++; $display("FAIL rst_mid_outputs got=%h_%h exp=0_0", instruction, data_send); end
      total++; if ({mem_ready, mem_err} !== 2'b00) begin bad++; $display("FAIL rst_mid_ready got=%b exp=00", {mem_ready, mem_err}); end
      total++; if (state !== IDLE) begin bad++; $display("FAIL rst_mid_state got=%0d exp=0", state); end
    end
    @(negedge clk); rst = 1'b1;
    begin
      int pulses = 0;
      repeat (5) begin @(posedge clk); #1; if (mem_ready) pulses++; end
      total++; if (pulses !== 0) begin bad++; $display("FAIL rst_no_ready got=%0d exp=0", pulses); end
    end
    // Reset while a write sits in RESP must not commit it.
    @(negedge clk); mem_write = 1'b1; address_data = 32'h4; data_receive = 32'h99;
    repeat (3) @(posedge clk);
    #1;
    total++; if (state !== RESP) begin bad++; $display("FAIL rst_wr_in_resp got=%0d exp=2", state); end
    @(negedge clk); rst = 1'b0; mem_write = 1'b0;
    @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    total++; if (instruction !== 32'h11223344) begin bad++; $display("FAIL rst_no_commit got=%h exp=11223344", instruction); end
  endtask

  task automatic test_write_read();
    int lat; logic err; logic [31:0] d;
    do_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, lat, err, d);
    total++; if (lat !== 3) begin bad++; $display("FAIL wr_latency got=%0d exp=3", lat); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL wr_err got=%b exp=0", err); end
    finish_access();
    do_access(1'b1, 1'b0, 32'h10, 32'h0, lat, err, d);
    total++; if (lat !== 3) begin bad++; $display("FAIL rd_latency got=%0d exp=3", lat); end
    total++; if (d !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data got=%h exp=deadbeef", d); end
    finish_access();
    total++; if (data_send !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data_hold got=%h exp=deadbeef", data_send); end
  endtask

  task automatic test_illegal();
    int lat; logic err; logic [31:0] d;
    do_access(1'b0, 1'b1, 32'h0, 32'hA5A50F0F, lat, err, d); finish_access();
    do_access(1'b1, 1'b0, 32'h0, 32'h0, lat, err, d); finish_access();
    total++; if (d !== 32'hA5A50F0F) begin bad++; $display("FAIL ill_setup got=%h exp=a5a50f0f", d); end
    do_access(1'b1, 1'b0, 32'h12, 32'h0, lat, err, d);
    total++; if ({lat == 1, err, d} !== {1'b1, 1'b1, 32'h0}) begin bad++; $display("FAIL ill_misaligned got=lat%0d err%b d%h exp=lat1 err1 d0", lat, err, d); end
    finish_access();
    do_access(1'b1, 1'b0, 32'h400, 32'h0, lat, err, d);
    total++; if ({lat == 1, err, d} !== {1'b1, 1'b1, 32'h0}) begin bad++; $display("FAIL ill_range got=lat%0d err%b d%h exp=lat1 err1 d0", lat, err, d); end
    finish_access();
    do_access(1'b0, 1'b1, 32'h2, 32'hFFFFFFFF, lat, err, d);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL ill_wr_misaligned got=%b exp=1", err); end
    finish_access();
    @(negedge clk); address_inst = 32'h0;
    @(posedge clk); #1;
    total++; if (instruction !== 32'hA5A50F0F) begin bad++; $display("FAIL ill_mem0 got=%h exp=a5a50f0f", instruction); end
  endtask

  task automatic test_both_ops();
    int lat; logic err; logic [31:0] d;
    do_access(1'b0, 1'b1, 32'h20, 32'h000055AA, lat, err, d); finish_access();
    do_access(1'b1, 1'b1, 32'h20, 32'hFFFFFFFF, lat, err, d);
    total++; if ({lat == 1, err} !== 2'b11) begin bad++; $display("FAIL both_err got=lat%0d err%b exp=lat1 err1", lat, err); end
    finish_access();
    @(negedge clk); address_inst = 32'h20;
    @(posedge clk); #1;
    total++; if (instruction !== 32'h000055AA) begin bad++; $display("FAIL both_mem8 got=%h exp=000055aa", instruction); end
  endtask

  task automatic test_hold();
    int lat; logic err; logic [31:0] d; int pulses;
    do_access(1'b1, 1'b0, 32'h10, 32'h0, lat, err, d);
    total++; if (lat !== 3) begin bad++; $display("FAIL hold_first got=%0d exp=3", lat); end
    pulses = 0;
    repeat (10) begin @(posedge clk); #1; if (mem_ready) pulses++; end
    total++; if (pulses !== 0) begin bad++; $display("FAIL hold_extra_pulses got=%0d exp=0", pulses); end
    total++; if (state !== RELEASE) begin bad++; $display("FAIL hold_state got=%0d exp=3", state); end
    finish_access();
    total++; if (state !== IDLE) begin bad++; $display("FAIL hold_idle got=%0d exp=0", state); end
    do_access(1'b1, 1'b0, 32'h10, 32'h0, lat, err, d);
    total++; if ({lat == 3, d} !== {1'b1, 32'hDEADBEEF}) begin bad++; $display("FAIL hold_second got=lat%0d d%h exp=lat3 ddeadbeef", lat, d); end
    finish_access();
  endtask

  task automatic test_fetch_rbw();
    int lat; logic err; logic [31:0] d;
    do_access(1'b0, 1'b1, 32'h40, 32'h0BADF00D, lat, err, d); finish_access();
    @(negedge clk); start = 1'b0; address_inst = 32'h40;
    do_access(1'b0, 1'b1, 32'h40, 32'h00001234, lat, err, d);
    total++; if (lat !== 3) begin bad++; $display("FAIL rbw_latency got=%0d exp=3", lat); end
    @(posedge clk); #1;
    total++; if (instruction !== 32'h0BADF00D) begin bad++; $display("FAIL rbw_old got=%h exp=0badf00d", instruction); end
    @(posedge clk); #1;
    total++; if (instruction !== 32'h00001234) begin bad++; $display("FAIL rbw_new got=%h exp=00001234", instruction); end
    finish_access();
    @(negedge clk); address_inst = 32'h43;
    @(posedge clk); #1;
    total++; if (instruction !== 32'h00001234) begin bad++; $display("FAIL fetch_lowbits got=%h exp=00001234", instruction); end
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    total++; if (instruction !== 32'h0) begin bad++; $display("FAIL fetch_start got=%h exp=0", instruction); end
    @(negedge clk); start = 1'b0; address_inst = 32'h400;
    @(posedge clk); #1;
    total++; if (instruction !== 32'h0) begin bad++; $display("FAIL fetch_range got=%h exp=0", instruction); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_illegal();
    test_both_ops();
    test_hold();
    test_fetch_rbw();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
